// File: rtl/sram_burst_ctrl_if.sv
// Upstream command, write-beat and read-return bundle for sram_burst_ctrl.
// master = bus/DMA side, slave = controller side.
interface sram_burst_ctrl_if #(
  parameter int unsigned DW    = 8,
  parameter int unsigned AW    = 10,
  parameter int unsigned LEN_W = 4
);
  logic             cmd_valid;
  logic             cmd_ready;
  logic             cmd_write;
  logic [AW-1:0]    cmd_addr;
  logic [LEN_W-1:0] cmd_len;

  logic             wr_valid;
  logic             wr_ready;
  logic [DW-1:0]    wr_data;

  logic             rd_valid;
  logic             rd_ready;
  logic [DW-1:0]    rd_data;
  logic             rd_perr;

  logic             done;

  modport master (
    output cmd_valid, cmd_write, cmd_addr, cmd_len, wr_valid, wr_data, rd_ready,
    input  cmd_ready, wr_ready, rd_valid, rd_data, rd_perr, done
  );

  modport slave (
    input  cmd_valid, cmd_write, cmd_addr, cmd_len, wr_valid, wr_data, rd_ready,
    output cmd_ready, wr_ready, rd_valid, rd_data, rd_perr, done
  );
endinterface

// File: rtl/sram_burst_ctrl.sv
// Burst read/write sequencer in front of a single-port synchronous SRAM.
// Optional even parity on the SRAM word: define SRAM_CTRL_PARITY_EN.
module sram_burst_ctrl #(
  parameter int unsigned DW    = 8,
  parameter int unsigned AW    = 10,
  parameter int unsigned LEN_W = 4,
`ifdef SRAM_CTRL_PARITY_EN
  localparam int unsigned SW   = DW + 1
`else
  localparam int unsigned SW   = DW
`endif
) (
  input  logic          clk,
  input  logic          rst_n,
  sram_burst_ctrl_if.slave bus,
  output logic          sram_cs,
  output logic          sram_we,
  output logic          sram_oe,
  output logic [AW-1:0] sram_addr,
  output logic [SW-1:0] sram_wdata,
  input  logic [SW-1:0] sram_rdata
);

  localparam logic [2:0] S_IDLE    = 3'd0;
  localparam logic [2:0] S_WR      = 3'd1;
  localparam logic [2:0] S_RD_ISS  = 3'd2;
  localparam logic [2:0] S_RD_CAP  = 3'd3;
  localparam logic [2:0] S_RD_HOLD = 3'd4;

  logic [2:0]       state_q,    state_d;
  logic [AW-1:0]    addr_q,     addr_d;
  logic [LEN_W-1:0] rem_q,      rem_d;
  logic             rd_valid_q, rd_valid_d;
  logic [DW-1:0]    rd_data_q,  rd_data_d;
  logic             rd_perr_q,  rd_perr_d;
  logic             done_q,     done_d;

  // Address only moves on accepted beats, so it holds between bursts.
  assign sram_addr    = addr_q;
  assign bus.rd_valid = rd_valid_q;
  assign bus.rd_data  = rd_data_q;
  assign bus.rd_perr  = rd_perr_q;
  assign bus.done     = done_q;

  always_comb begin
    state_d       = state_q;
    addr_d        = addr_q;
    rem_d         = rem_q;
    rd_valid_d    = rd_valid_q;
    rd_data_d     = rd_data_q;
    rd_perr_d     = rd_perr_q;
    done_d        = 1'b0;
    bus.cmd_ready = 1'b0;
    bus.wr_ready  = 1'b0;
    sram_cs       = 1'b0;
    sram_we       = 1'b0;
    sram_oe       = 1'b0;
    sram_wdata    = '0;

    case (state_q)
      S_IDLE: begin
        bus.cmd_ready = 1'b1;
        if (bus.cmd_valid) begin
          addr_d  = bus.cmd_addr;
          rem_d   = bus.cmd_len;
          state_d = bus.cmd_write ? S_WR : S_RD_ISS;
        end
      end

      // Write beats stream straight to the SRAM; wr_valid gaps stall.
      S_WR: begin
        bus.wr_ready = 1'b1;
        sram_cs      = 1'b1;
        sram_we      = bus.wr_valid;
`ifdef SRAM_CTRL_PARITY_EN
        sram_wdata   = {^bus.wr_data, bus.wr_data};
`else
        sram_wdata   = bus.wr_data;
`endif
        if (bus.wr_valid) begin
          if (rem_q == '0) begin
            state_d = S_IDLE;
            done_d  = 1'b1;
          end else begin
            rem_d  = LEN_W'(rem_q - 1'b1);
            addr_d = AW'(addr_q + 1'b1);
          end
        end
      end

      S_RD_ISS: begin
        sram_cs = 1'b1;
        sram_oe = 1'b1;
        state_d = S_RD_CAP;
      end

      // SRAM output register is valid in this cycle.
      S_RD_CAP: begin
        rd_data_d  = sram_rdata[DW-1:0];
        rd_valid_d = 1'b1;
`ifdef SRAM_CTRL_PARITY_EN
        rd_perr_d  = ^sram_rdata;
`endif
        state_d    = S_RD_HOLD;
      end

      S_RD_HOLD: begin
        if (bus.rd_ready) begin
          rd_valid_d = 1'b0;
          if (rem_q == '0) begin
            state_d = S_IDLE;
            done_d  = 1'b1;
          end else begin
            rem_d   = LEN_W'(rem_q - 1'b1);
            addr_d  = AW'(addr_q + 1'b1);
            state_d = S_RD_ISS;
          end
        end
      end

      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= S_IDLE;
      addr_q     <= '0;
      rem_q      <= '0;
      rd_valid_q <= 1'b0;
      rd_data_q  <= '0;
      rd_perr_q  <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      addr_q     <= addr_d;
      rem_q      <= rem_d;
      rd_valid_q <= rd_valid_d;
      rd_data_q  <= rd_data_d;
      rd_perr_q  <= rd_perr_d;
      done_q     <= done_d;
    end
  end

endmodule
